// File: rtl/seq_detect_param.sv
// Purpose: serial pattern detector with a runtime-loadable pattern, selectable
//          overlapping/non-overlapping mode and an optional saturating match counter.
// Latency/backpressure: detect is Mealy (same cycle as x); no backpressure, a bit is consumed whenever in_valid is high.
//
// Ports:
//   clk          rising-edge clock for all state
//   reset_n      asynchronous active-low reset
//   x            serial data bit, qualified by in_valid
//   in_valid     high when x carries a bit to consume
//   cfg_load     one-cycle pulse: latch cfg_pattern/cfg_overlap, flush history
//   cfg_pattern  new pattern, MSB is the first bit received
//   cfg_overlap  1 = overlapping matches, 0 = non-overlapping
//   count_clr    synchronous clear of match_count (wins over an increment)
//   detect       combinational match flag
//   match_count  saturating number of detections
//
// Optional feature: define SEQ_DET_COUNT_EN to build the match counter.
// Without it match_count is tied to 0 and count_clr has no effect.
module seq_detect_param #(
    parameter int unsigned      PAT_W     = 3,
    parameter int unsigned      CNT_W     = 8,
    parameter logic [PAT_W-1:0] RESET_PAT = 3'b101
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             x,
    input  logic             in_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             count_clr,
    output logic             detect,
    output logic [CNT_W-1:0] match_count
);

    // Fill counter only needs to reach PAT_W-1.
    localparam int unsigned      FILL_W    = (PAT_W <= 2) ? 1 : $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    logic [PAT_W-1:0]  r_pat;
    logic              r_ovl;

    logic [PAT_W-1:0]  w_window;
    logic              w_full;
    logic              w_detect;
    logic [PAT_W-2:0]  w_hist_nxt;
    logic [FILL_W-1:0] w_fill_nxt;
    logic [PAT_W-1:0]  w_pat_nxt;
    logic              w_ovl_nxt;

    // Candidate window: stored history followed by the bit arriving now.
    assign w_window = {r_hist, x};
    assign w_full   = (r_fill == FILL_FULL);

    // reset_n is folded in so detect is quiet while reset is held, even
    // though the registers already read as empty.
    assign w_detect = reset_n & in_valid & ~cfg_load & w_full & (w_window == r_pat);
    assign detect   = w_detect;

    always_comb begin
        w_hist_nxt = r_hist;
        w_fill_nxt = r_fill;
        w_pat_nxt  = r_pat;
        w_ovl_nxt  = r_ovl;
        if (cfg_load) begin
            // New pattern: the bit presented this cycle is discarded.
            w_pat_nxt  = cfg_pattern;
            w_ovl_nxt  = cfg_overlap;
            w_hist_nxt = '0;
            w_fill_nxt = '0;
        end else if (in_valid) begin
            if (w_detect) begin
                if (r_ovl) begin
                    // Matched bits may seed the next match; fill stays full.
                    w_hist_nxt = w_window[PAT_W-2:0];
                end else begin
                    // Next match must be built from PAT_W fresh bits.
                    w_hist_nxt = '0;
                    w_fill_nxt = '0;
                end
            end else begin
                w_hist_nxt = w_window[PAT_W-2:0];
                if (!w_full) begin
                    w_fill_nxt = r_fill + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hist <= '0;
            r_fill <= '0;
            r_pat  <= RESET_PAT;
            r_ovl  <= 1'b0;
        end else begin
            r_hist <= w_hist_nxt;
            r_fill <= w_fill_nxt;
            r_pat  <= w_pat_nxt;
            r_ovl  <= w_ovl_nxt;
        end
    end

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] r_count;
    logic             w_count_sat;

    assign w_count_sat = (r_count == {CNT_W{1'b1}});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (count_clr) begin
            r_count <= '0;
        end else if (w_detect && !w_count_sat) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign match_count = r_count;
`else
    logic w_unused_count_clr;

    assign w_unused_count_clr = count_clr;
    assign match_count        = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

`ifdef SEQ_DET_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic       x;
    logic       in_valid;
    logic       cfg_load;
    logic [2:0] cfg_pattern;
    logic       cfg_overlap;
    logic       count_clr;
    logic       detect;
    logic       detect2;
    logic [7:0] match_count;
    logic [1:0] match_count2;

    int errors = 0;
    int checks = 0;

    seq_detect_param dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .x           (x),
        .in_valid    (in_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .count_clr   (count_clr),
        .detect      (detect),
        .match_count (match_count)
    );

    seq_detect_param #(.CNT_W(2)) dut2 (
        .clk         (clk),
        .reset_n     (reset_n),
        .x           (x),
        .in_valid    (in_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .count_clr   (count_clr),
        .detect      (detect2),
        .match_count (match_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected counter values: 8-bit instance and 2-bit saturating instance.
    function automatic logic [31:0] ec(input int unsigned n);
        return CNT_EN ? 32'(n) : 32'd0;
    endfunction

    function automatic logic [31:0] ec2(input int unsigned n);
        return CNT_EN ? ((n > 3) ? 32'd3 : 32'(n)) : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] e1, input logic [31:0] e2);
        chk({tag, "_cnt"},  32'(match_count),  e1);
        chk({tag, "_cnt2"}, 32'(match_count2), e2);
    endtask

    // One cycle: drive at negedge, check Mealy output before the rising edge.
    task automatic vstep(input string tag, input logic v, input logic xb, input logic exp_det);
        in_valid  = v;
        x         = xb;
        cfg_load  = 1'b0;
        count_clr = 1'b0;
        #1;
        chk({tag, "_det"},  32'(detect),  32'(exp_det));
        chk({tag, "_det2"}, 32'(detect2), 32'(exp_det));
        @(negedge clk);
    endtask

    // cfg_load with a valid '1' present; detect must stay low.
    task automatic cfg(input string tag, input logic [2:0] p, input logic o);
        cfg_load    = 1'b1;
        cfg_pattern = p;
        cfg_overlap = o;
        in_valid    = 1'b1;
        x           = 1'b1;
        count_clr   = 1'b0;
        #1;
        chk({tag, "_det"}, 32'(detect), 32'd0);
        @(negedge clk);
        cfg_load = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic clr();
        count_clr = 1'b1;
        in_valid  = 1'b0;
        cfg_load  = 1'b0;
        @(negedge clk);
        count_clr = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        x           = 1'b1;
        in_valid    = 1'b1;
        cfg_load    = 1'b0;
        cfg_pattern = 3'b000;
        cfg_overlap = 1'b0;
        count_clr   = 1'b0;

        // Reset state, with a valid '1' presented.
        #1;
        chk("rst_det",  32'(detect),  32'd0);
        chk("rst_det2", 32'(detect2), 32'd0);
        chk_cnt("rst", 32'd0, 32'd0);
        @(negedge clk);
        chk("rst_det_edge", 32'(detect), 32'd0);
        reset_n  = 1'b1;
        in_valid = 1'b0;

        // Default 101, non-overlapping: 1,0,1,0,1 -> only 3rd bit.
        vstep("d1", 1'b1, 1'b1, 1'b0);
        vstep("d2", 1'b1, 1'b0, 1'b0);
        vstep("d3", 1'b1, 1'b1, 1'b1);
        vstep("d4", 1'b1, 1'b0, 1'b0);
        vstep("d5", 1'b1, 1'b1, 1'b0);
        chk_cnt("dflt", ec(1), ec2(1));

        // Overlapping 101: 3rd and 5th bits.
        clr();
        chk_cnt("clr_a", 32'd0, 32'd0);
        cfg("ov_cfg", 3'b101, 1'b1);
        vstep("o1", 1'b1, 1'b1, 1'b0);
        vstep("o2", 1'b1, 1'b0, 1'b0);
        vstep("o3", 1'b1, 1'b1, 1'b1);
        vstep("o4", 1'b1, 1'b0, 1'b0);
        vstep("o5", 1'b1, 1'b1, 1'b1);
        chk_cnt("ovl", ec(2), ec2(2));

        // Gaps with x=1 must not be consumed or flag a match.
        cfg("gap_cfg", 3'b101, 1'b0);
        vstep("g1", 1'b1, 1'b1, 1'b0);
        vstep("g2", 1'b0, 1'b1, 1'b0);
        vstep("g3", 1'b0, 1'b1, 1'b0);
        vstep("g4", 1'b1, 1'b0, 1'b0);
        vstep("g5", 1'b0, 1'b1, 1'b0);
        vstep("g6", 1'b1, 1'b1, 1'b1);
        chk_cnt("gap", ec(3), ec2(3));

        // Reconfigure mid-stream: the cfg cycle would match old 101.
        vstep("c1", 1'b1, 1'b1, 1'b0);
        vstep("c2", 1'b1, 1'b0, 1'b0);
        cfg("c_cfg", 3'b110, 1'b0);
        vstep("c3", 1'b1, 1'b1, 1'b0);
        vstep("c4", 1'b1, 1'b1, 1'b0);
        vstep("c5", 1'b1, 1'b0, 1'b1);
        chk_cnt("cfg", ec(4), ec2(4));

        // cfg_load leaves the counter alone; then saturation on 2-bit counter.
        cfg("s_cfg", 3'b101, 1'b0);
        chk_cnt("cfg_keep", ec(4), ec2(4));
        clr();
        chk_cnt("clr_b", 32'd0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            vstep("s1", 1'b1, 1'b1, 1'b0);
            vstep("s2", 1'b1, 1'b0, 1'b0);
            vstep("s3", 1'b1, 1'b1, 1'b1);
            if (i == 2) chk_cnt("sat3", ec(3), ec2(3));
        end
        chk_cnt("sat5", ec(5), ec2(5));

        // count_clr beats a same-cycle detect.
        vstep("k1", 1'b1, 1'b1, 1'b0);
        vstep("k2", 1'b1, 1'b0, 1'b0);
        in_valid  = 1'b1;
        x         = 1'b1;
        count_clr = 1'b1;
        #1;
        chk("k3_det", 32'(detect), 32'd1);
        @(negedge clk);
        count_clr = 1'b0;
        in_valid  = 1'b0;
        chk_cnt("clr_win", 32'd0, 32'd0);

        // Mid-sequence reset restores 101/non-overlap and clears history.
        cfg("r_cfg", 3'b011, 1'b1);
        vstep("r1", 1'b1, 1'b0, 1'b0);
        vstep("r2", 1'b1, 1'b1, 1'b0);
        vstep("r3", 1'b1, 1'b1, 1'b1);
        vstep("r4", 1'b1, 1'b0, 1'b0);
        chk_cnt("pre_rst", ec(1), ec2(1));
        reset_n  = 1'b0;
        in_valid = 1'b1;
        x        = 1'b1;
        #1;
        chk("mrst_det", 32'(detect), 32'd0);
        chk_cnt("mrst_async", 32'd0, 32'd0);
        @(negedge clk);
        chk("mrst_det_edge", 32'(detect), 32'd0);
        reset_n = 1'b1;
        vstep("p1", 1'b1, 1'b1, 1'b0);
        vstep("p2", 1'b1, 1'b1, 1'b0);
        vstep("p3", 1'b1, 1'b0, 1'b0);
        vstep("p4", 1'b1, 1'b1, 1'b1);
        chk_cnt("post_rst", ec(1), ec2(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_W, default 3: pattern length in bits, legal range 2..16.
REQ-002 Parameter CNT_W, default 8: width of match counter, legal range 1..32.
REQ-003 Parameter RESET_PAT, default 3'b101 (PAT_W bits): pattern loaded at reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 x  input  1  serial data bit.
REQ-007 in_valid  input  1  qualifies x; bit consumed only when high.
REQ-008 cfg_load  input  1  one-cycle pulse; latches cfg_pattern and cfg_overlap.
REQ-009 cfg_pattern  input  PAT_W  new pattern; MSB is first bit received.
REQ-010 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-011 count_clr  input  1  synchronous clear of match_count.
REQ-012 detect  output  1  Mealy match flag, combinational from current x and in_valid.
REQ-013 match_count  output  CNT_W  saturating count of detections.

Function
REQ-014 Block SHALL hold history register hist (PAT_W-1 bits), fill counter fill (0..PAT_W-1), pattern register pat and mode bit ovl.
REQ-015 detect SHALL equal in_valid & !cfg_load & (fill == PAT_W-1) & ({hist, x} == pat), same cycle as x, no registered latency.
REQ-016 On a valid cycle without detect, hist SHALL shift left taking x into LSB, and fill SHALL increment, saturating at PAT_W-1.
REQ-017 On detect with ovl=1, hist SHALL shift in x and fill SHALL stay at PAT_W-1 (overlapping matches allowed).
REQ-018 On detect with ovl=0, hist and fill SHALL clear to 0, so the next match needs PAT_W fresh valid bits.
REQ-019 Cycles with in_valid=0 SHALL leave hist, fill and match_count unchanged and force detect=0.
REQ-020 cfg_load SHALL take pat<=cfg_pattern, ovl<=cfg_overlap, clear hist and fill, and ignore x that cycle.
REQ-021 match_count SHALL increment by 1 on each detect, saturating at 2^CNT_W-1 (no wrap).
REQ-022 count_clr SHALL set match_count to 0 and take priority over a same-cycle increment.
REQ-023 cfg_load SHALL NOT alter match_count.

Reset
REQ-024 reset_n low SHALL immediately set hist=0, fill=0, pat=RESET_PAT, ovl=0, match_count=0.
REQ-025 detect SHALL be 0 during reset regardless of x and in_valid.
REQ-026 Reset asserted mid-sequence SHALL discard partial history; deassertion needs no extra idle cycles.

Configuration
REQ-027 Macro SEQ_DET_COUNT_EN SHALL compile in the match_count register, its increment, saturation and count_clr logic.
REQ-028 Without SEQ_DET_COUNT_EN, match_count SHALL be tied to 0, count_clr ignored, and detection behaviour unchanged.

Verification
REQ-029 Reset, defaults (101, ovl=0), valid bits 1,0,1,0,1 -> detect high on 3rd bit only, match_count=1.
REQ-030 cfg_load pattern 101 ovl=1, bits 1,0,1,0,1 -> detect on 3rd and 5th bits, match_count=2.
REQ-031 Default config, bits 1, gap(in_valid=0) x2, 0, gap, 1 -> detect=0 in gaps, detect=1 on final bit.
REQ-032 After bits 1,0, cfg_load pattern 110 ovl=0, then bits 1,1,0 -> no detect on first 1, detect on final 0.
REQ-033 CNT_W=2, five non-overlapped 101 matches -> match_count stays 3; count_clr with a detect -> match_count=0.
REQ-034 Bits 1,0 then reset_n low one cycle, then bit 1 -> detect=0, outputs 0 during reset; 1,0,1 afterwards -> detect.
